multicycle_ctrl_seq: RTL and testbench
======================================

Name: multicycle_ctrl_seq

Overview:
Opcode-aware multicycle control sequencer for the accumulator datapath. It generates the one-hot control strobes MRd, Mwr, ld_pc, Inc_pc, ld_IR, Ld_acc and ALU_setup. Fetch, load, execute and store steps are chained per instruction class instead of following a fixed 8-step count. Memory accesses use a ready handshake with a timeout, and the block adds run/halt control.

Parameters:
OPW, 4, opcode width
OP_LD, 4'h8, load opcode value
OP_ST, 4'h9, store opcode value
OP_BR, 4'hA, conditional-branch opcode value
OP_HALT, 4'hF, halt opcode value; every other opcode is ALU class
TIMEOUT, 16, max wait cycles for mem_rdy; 0 disables the timeout
CNTW, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable, sampled at instruction boundaries
opcode  in  OPW  opcode field from IR; stable from DECODE until the next ld_IR
mem_rdy  in  1  memory read/write complete (sampled in wait states)
br_flag  in  1  branch condition, sampled in DECODE
MRd  out  1  memory read strobe
Mwr  out  1  memory write strobe
ld_pc  out  1  load PC (branch target)
Inc_pc  out  1  increment PC
ld_IR  out  1  load instruction register
Ld_acc  out  1  load accumulator
ALU_setup  out  1  ALU operation select/setup
halted  out  1  FSM in HALT
err_timeout  out  1  sticky memory-timeout error
state  out  4  current state code
instr_cnt  out  CNTW  retired instructions (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, all strobes, halted, err_timeout and instr_cnt = 0. Reset is honoured from every state, including mid-wait.
- Outputs are registered Moore outputs: a strobe is high exactly during the cycles the FSM occupies its state, with no combinational path from inputs. At most one strobe is high at any time.
- State codes:
  - IDLE=0 (no strobe)
  - FETCH=1 (MRd)
  - LD_IR=2 (ld_IR)
  - INC=3 (Inc_pc)
  - DECODE=4 (no strobe)
  - EXEC=5 (ALU_setup)
  - MEM_RD=6 (MRd)
  - MEM_WR=7 (Mwr)
  - WB=8 (Ld_acc)
  - BR_LD=9 (ld_pc)
  - HALT=15 (halted=1)
- Transitions:
  - IDLE -> FETCH when en=1; otherwise stay in IDLE.
  - FETCH: stay while mem_rdy=0; -> LD_IR when mem_rdy=1.
  - LD_IR -> INC -> DECODE, one cycle each.
  - DECODE by opcode:
    - OP_HALT -> HALT
    - OP_LD -> MEM_RD
    - OP_ST -> MEM_WR
    - OP_BR -> BR_LD if br_flag=1, else end of instruction
    - any other opcode -> EXEC
  - EXEC -> WB. MEM_RD waits on mem_rdy, then -> WB. WB -> end. MEM_WR waits on mem_rdy, then -> end. BR_LD -> end.
  - End of instruction: -> FETCH if en=1, else -> IDLE. en=0 mid-instruction does not abort the instruction.
  - HALT is absorbing; only rst exits it.
- Instruction latency with mem_rdy already high:
  - ALU: 6 cycles
  - LD: 6 cycles
  - ST: 5 cycles
  - BR taken: 5 cycles
  - BR not taken: 4 cycles
  - HALT: 4 cycles to reach HALT
- Timeout (TIMEOUT>0):
  - Wait counter, width $clog2(TIMEOUT+1), clears on entry to FETCH/MEM_RD/MEM_WR.
  - The counter increments each wait-state cycle with mem_rdy=0.
  - On the TIMEOUT-th consecutive such cycle: err_timeout<=1 and next state HALT.
  - If mem_rdy=1 arrives in that same cycle, mem_rdy wins and there is no error.
  - err_timeout is cleared only by rst.
- TIMEOUT=0: the FSM waits on mem_rdy indefinitely and err_timeout stays 0.

Optional Feature:
INSTR_CNT_EN
- Defined: instr_cnt increments by 1 at each end of instruction, i.e. on the exits of WB, MEM_WR, BR_LD, and DECODE for a not-taken branch. Entering HALT does not count. The counter wraps modulo 2^CNTW with no flag.
- Undefined: the port is present and tied to 0, and no counter logic is built.

Test Plan:
- rst, en=1, mem_rdy=1, opcode=4'h1 -> state sequence 1,2,3,4,5,8,1. MRd, ld_IR, Inc_pc, (none), ALU_setup, Ld_acc each high one cycle in that order. instr_cnt=1 after WB (with INSTR_CNT_EN).
- opcode=OP_LD with mem_rdy low for 3 cycles in MEM_RD -> MRd high 4 cycles, then Ld_acc one cycle. OP_ST the same way -> Mwr high until mem_rdy, with no Ld_acc.
- opcode=OP_BR: br_flag=1 -> ld_pc pulses one cycle after DECODE. br_flag=0 -> FETCH directly after DECODE, and ld_pc never asserts.
- mem_rdy held 0 in FETCH, TIMEOUT=16 -> 16 MRd cycles, then state=15, halted=1, err_timeout=1. A second run with mem_rdy=1 on the 16th cycle -> LD_IR follows and err_timeout=0.
- en dropped during EXEC -> WB completes, then IDLE with all strobes 0. en reasserted -> FETCH on the next cycle.
- OP_HALT -> HALT held for 50 cycles regardless of en/mem_rdy. rst asserted mid-MEM_RD on another run -> next cycle state=0 with all outputs 0. Preload instr_cnt=2^CNTW-1 (or run until it wraps) -> it wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_seq_if.sv
// Control bus between the multicycle sequencer and the accumulator datapath.
// master: the sequencer (drives strobes and status, samples datapath inputs).
// slave:  the datapath / memory side (drives run enable, opcode, ready, branch flag).
interface multicycle_ctrl_seq_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
);
  logic            en;
  logic [OPW-1:0]  opcode;
  logic            mem_rdy;
  logic            br_flag;

  logic            MRd;
  logic            Mwr;
  logic            ld_pc;
  logic            Inc_pc;
  logic            ld_IR;
  logic            Ld_acc;
  logic            ALU_setup;
  logic            halted;
  logic            err_timeout;
  logic [3:0]      state;
  logic [CNTW-1:0] instr_cnt;

  modport master (
    input  en, opcode, mem_rdy, br_flag,
    output MRd, Mwr, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup,
    output halted, err_timeout, state, instr_cnt
  );

  modport slave (
    output en, opcode, mem_rdy, br_flag,
    input  MRd, Mwr, ld_pc, Inc_pc, ld_IR, Ld_acc, ALU_setup,
    input  halted, err_timeout, state, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// Opcode-aware multicycle control sequencer for the accumulator datapath.
// Chains fetch / decode / execute / memory / write-back steps per instruction
// class, waits on mem_rdy with an optional timeout, and provides run/halt control.
// All strobes are registered Moore outputs decoded from the next state, so they
// line up exactly with the cycles the FSM spends in each state.
// Optional feature macro: INSTR_CNT_EN (retired-instruction counter on instr_cnt;
// when undefined instr_cnt is tied to zero and no counter is built).
module multicycle_ctrl_seq #(
  parameter int             OPW     = 4,
  parameter logic [OPW-1:0] OP_LD   = 4'h8,
  parameter logic [OPW-1:0] OP_ST   = 4'h9,
  parameter logic [OPW-1:0] OP_BR   = 4'hA,
  parameter logic [OPW-1:0] OP_HALT = 4'hF,
  parameter int             TIMEOUT = 16,
  parameter int             CNTW    = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    LD_IR  = 4'd2,
    INC    = 4'd3,
    DECODE = 4'd4,
    EXEC   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WR = 4'd7,
    WB     = 4'd8,
    BR_LD  = 4'd9,
    HALT   = 4'd15
  } state_t;

  // Wait counter is at least one bit wide so TIMEOUT=0 still elaborates cleanly.
  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t         cur;
  state_t         nxt;
  logic [WCW-1:0] wcnt;
  logic           in_wait;
  logic           tmo_hit;

  assign bus.state = cur;

  // Next-state selection: instruction-class chaining, memory waits and timeout.
  always_comb begin
    nxt     = cur;
    in_wait = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
    tmo_hit = (TIMEOUT > 0) && in_wait && !bus.mem_rdy &&
              (wcnt == WCW'(TIMEOUT - 1));
    case (cur)
      IDLE:   if (bus.en) nxt = FETCH;
      FETCH: begin
        if (bus.mem_rdy)  nxt = LD_IR;
        else if (tmo_hit) nxt = HALT;
      end
      LD_IR:  nxt = INC;
      INC:    nxt = DECODE;
      DECODE: begin
        if (bus.opcode == OP_HALT)    nxt = HALT;
        else if (bus.opcode == OP_LD) nxt = MEM_RD;
        else if (bus.opcode == OP_ST) nxt = MEM_WR;
        else if (bus.opcode == OP_BR) nxt = bus.br_flag ? BR_LD : (bus.en ? FETCH : IDLE);
        else                          nxt = EXEC;
      end
      EXEC:   nxt = WB;
      MEM_RD: begin
        if (bus.mem_rdy)  nxt = WB;
        else if (tmo_hit) nxt = HALT;
      end
      WB:     nxt = bus.en ? FETCH : IDLE;
      MEM_WR: begin
        if (bus.mem_rdy)  nxt = bus.en ? FETCH : IDLE;
        else if (tmo_hit) nxt = HALT;
      end
      BR_LD:  nxt = bus.en ? FETCH : IDLE;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // State register with registered one-hot strobes, sticky timeout and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur             <= IDLE;
      bus.MRd         <= 1'b0;
      bus.Mwr         <= 1'b0;
      bus.ld_pc       <= 1'b0;
      bus.Inc_pc      <= 1'b0;
      bus.ld_IR       <= 1'b0;
      bus.Ld_acc      <= 1'b0;
      bus.ALU_setup   <= 1'b0;
      bus.halted      <= 1'b0;
      bus.err_timeout <= 1'b0;
      wcnt            <= '0;
    end else begin
      cur           <= nxt;
      bus.MRd       <= (nxt == FETCH) || (nxt == MEM_RD);
      bus.Mwr       <= (nxt == MEM_WR);
      bus.ld_pc     <= (nxt == BR_LD);
      bus.Inc_pc    <= (nxt == INC);
      bus.ld_IR     <= (nxt == LD_IR);
      bus.Ld_acc    <= (nxt == WB);
      bus.ALU_setup <= (nxt == EXEC);
      bus.halted    <= (nxt == HALT);
      if (tmo_hit) bus.err_timeout <= 1'b1;
      if (nxt != cur)
        wcnt <= '0;
      else if (in_wait && !bus.mem_rdy && (TIMEOUT > 0))
        wcnt <= wcnt + 1'b1;
    end
  end

`ifdef INSTR_CNT_EN
  logic [CNTW-1:0] cnt;
  logic            instr_end;

  // An instruction retires when its last step hands control back to FETCH/IDLE.
  assign instr_end = (cur == WB) || (cur == BR_LD) ||
                     ((cur == MEM_WR) && bus.mem_rdy) ||
                     ((cur == DECODE) && (bus.opcode == OP_BR) && !bus.br_flag);

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (instr_end) cnt <= cnt + 1'b1;
  end

  assign bus.instr_cnt = cnt;
`else
  assign bus.instr_cnt = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Self-checking bench for multicycle_ctrl_seq. Each scenario builds an expected
// per-cycle trace from instruction-level rules (class, memory delays, run enable),
// then replays it against the DUT and compares state, strobes, error and counter.
module tb_multicycle_ctrl_seq;
  localparam int         TIMEOUT = 16;
  localparam int         CNTW    = 4;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_LD_IR = 4'd2, S_INC = 4'd3,
                         S_DECODE = 4'd4, S_EXEC = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                         S_WB = 4'd8, S_BR_LD = 4'd9, S_HALT = 4'd15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_seq_if #(.OPW(4), .CNTW(CNTW)) bus ();

  multicycle_ctrl_seq #(
    .OPW(4), .OP_LD(OP_LD), .OP_ST(OP_ST), .OP_BR(OP_BR), .OP_HALT(OP_HALT),
    .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One expected cycle: state entered at an edge, plus the inputs to drive while there.
  typedef struct {
    logic [3:0]      st;
    logic            rdy;
    logic            en;
    logic [3:0]      op;
    logic            br;
    logic            rst;
    logic            err;
    logic [CNTW-1:0] cnt;
  } ent_t;

  ent_t            q[$];
  ent_t            prv;
  logic [CNTW-1:0] m_cnt;
  logic            m_err;
  bit              pend_end;
  logic [3:0]      cur_op;
  logic            cur_br;
  int              vectors = 0;
  int              miscompares = 0;

  function automatic logic rnd();
    return $urandom_range(0, 1) != 0;
  endfunction

  // Strobe set implied by each state: MRd,Mwr,ld_pc,Inc_pc,ld_IR,Ld_acc,ALU_setup,halted.
  function automatic logic [7:0] strobes_of(input logic [3:0] st);
    case (st)
      S_FETCH, S_MEM_RD: return 8'b1000_0000;
      S_MEM_WR:          return 8'b0100_0000;
      S_BR_LD:           return 8'b0010_0000;
      S_INC:             return 8'b0001_0000;
      S_LD_IR:           return 8'b0000_1000;
      S_WB:              return 8'b0000_0100;
      S_EXEC:            return 8'b0000_0010;
      S_HALT:            return 8'b0000_0001;
      default:           return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] strb_obs();
    return {bus.MRd, bus.Mwr, bus.ld_pc, bus.Inc_pc, bus.ld_IR, bus.Ld_acc, bus.ALU_setup, bus.halted};
  endfunction

  function automatic logic [12+CNTW:0] obs_vec();
    return {bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt};
  endfunction

  function automatic logic [12+CNTW:0] exp_vec(input ent_t e);
    return {e.st, strobes_of(e.st), e.err, e.cnt};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic en);
    ent_t e;
    if (pend_end) begin
      m_cnt    = m_cnt + 1'b1;
      pend_end = 1'b0;
    end
    e.st  = st;
    e.rdy = rdy;
    e.en  = en;
    e.op  = cur_op;
    e.br  = cur_br;
    e.rst = 1'b0;
    e.err = m_err;
`ifdef INSTR_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = '0;
`endif
    q.push_back(e);
  endtask

  task automatic push_rst(input logic en);
    m_cnt    = '0;
    m_err    = 1'b0;
    pend_end = 1'b0;
    push(S_IDLE, rnd(), en);
    q[q.size()-1].rst = 1'b1;
  endtask

  // Memory wait of d not-ready cycles; a run of TIMEOUT not-ready cycles halts with error.
  task automatic add_wait(input logic [3:0] st, input int d, input logic end_en,
                          input bit is_end, output bit hlt);
    hlt = 1'b0;
    if (TIMEOUT > 0 && d >= TIMEOUT) begin
      for (int k = 0; k < TIMEOUT; k++) push(st, 1'b0, rnd());
      m_err = 1'b1;
      push(S_HALT, rnd(), rnd());
      hlt = 1'b1;
    end else begin
      for (int k = 0; k < d; k++) push(st, 1'b0, rnd());
      push(st, 1'b1, is_end ? end_en : rnd());
      if (is_end) pend_end = 1'b1;
    end
  endtask

  // Expected trace of one instruction; the preceding entry must have en=1.
  task automatic add_instr(input logic [3:0] op, input logic br, input int df, input int dm,
                           input logic en_end, output bit hlt);
    cur_op = op;
    cur_br = br;
    add_wait(S_FETCH, df, 1'b0, 1'b0, hlt);
    if (hlt) return;
    push(S_LD_IR, rnd(), rnd());
    push(S_INC, rnd(), rnd());
    if (op == OP_BR && !br) begin
      push(S_DECODE, rnd(), en_end);
      pend_end = 1'b1;
      return;
    end
    push(S_DECODE, rnd(), rnd());
    if (op == OP_HALT) begin
      push(S_HALT, rnd(), rnd());
      hlt = 1'b1;
    end else if (op == OP_LD) begin
      add_wait(S_MEM_RD, dm, 1'b0, 1'b0, hlt);
      if (!hlt) begin
        push(S_WB, rnd(), en_end);
        pend_end = 1'b1;
      end
    end else if (op == OP_ST) begin
      add_wait(S_MEM_WR, dm, en_end, 1'b1, hlt);
    end else if (op == OP_BR) begin
      push(S_BR_LD, rnd(), en_end);
      pend_end = 1'b1;
    end else begin
      push(S_EXEC, rnd(), rnd());
      push(S_WB, rnd(), en_end);
      pend_end = 1'b1;
    end
  endtask

  task automatic add_idle(input int n, input logic en_last);
    for (int k = 0; k < n - 1; k++) push(S_IDLE, rnd(), 1'b0);
    push(S_IDLE, rnd(), en_last);
  endtask

  task automatic add_halt(input int n);
    for (int k = 0; k < n; k++) push(S_HALT, rnd(), rnd());
  endtask

  // Drive the inputs belonging to the current state, clock once, settle after the edge.
  task automatic step(input ent_t e);
    rst         = e.rst;
    bus.mem_rdy = prv.rdy;
    bus.en      = prv.en;
    bus.opcode  = prv.op;
    bus.br_flag = prv.br;
    @(posedge clk);
    #1;
    prv = e;
  endtask

  task automatic test_reset();
    q.delete();
    cur_op = 4'h0;
    cur_br = 1'b0;
    push_rst(1'b0);
    push_rst(1'b0);
    add_idle(4, 1'b0);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL reset[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_instr_classes();
    bit h;
    q.delete();
    push_rst(1'b1);
    add_instr(4'h1, 1'b0, 0, 0, 1'b1, h);
    add_instr(OP_LD, 1'b0, 0, 3, 1'b1, h);
    add_instr(OP_ST, 1'b0, 0, 3, 1'b1, h);
    add_instr(OP_BR, 1'b1, 0, 0, 1'b1, h);
    add_instr(OP_BR, 1'b0, 0, 0, 1'b1, h);
    add_instr(4'h3, 1'b1, 2, 0, 1'b1, h);
    add_instr(OP_ST, 1'b0, 1, 0, 1'b0, h);
    add_idle(2, 1'b1);
    add_instr(OP_LD, 1'b0, 0, 0, 1'b1, h);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL instr_classes[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_timeout();
    bit h;
    q.delete();
    push_rst(1'b1);
    add_instr(4'h1, 1'b0, TIMEOUT - 1, 0, 1'b1, h);
    add_instr(OP_LD, 1'b0, 0, TIMEOUT - 1, 1'b1, h);
    add_instr(OP_ST, 1'b0, 0, TIMEOUT, 1'b1, h);
    add_halt(5);
    push_rst(1'b1);
    add_instr(4'h2, 1'b0, TIMEOUT, 0, 1'b1, h);
    add_halt(5);
    push_rst(1'b1);
    add_instr(OP_LD, 1'b0, 0, TIMEOUT, 1'b1, h);
    add_halt(3);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_en_drop();
    bit h;
    q.delete();
    push_rst(1'b1);
    add_instr(4'h5, 1'b0, 0, 0, 1'b0, h);
    add_idle(4, 1'b1);
    add_instr(4'h6, 1'b0, 0, 0, 1'b0, h);
    add_idle(1, 1'b1);
    add_instr(OP_BR, 1'b0, 0, 0, 1'b0, h);
    add_idle(3, 1'b0);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL en_drop[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_halt_and_rst();
    bit h;
    q.delete();
    push_rst(1'b1);
    add_instr(OP_BR, 1'b0, 1, 0, 1'b1, h);
    add_instr(OP_HALT, 1'b0, 0, 0, 1'b1, h);
    add_halt(50);
    push_rst(1'b1);
    cur_op = OP_LD;
    add_wait(S_FETCH, 0, 1'b0, 1'b0, h);
    push(S_LD_IR, rnd(), rnd());
    push(S_INC, rnd(), rnd());
    push(S_DECODE, rnd(), rnd());
    push(S_MEM_RD, 1'b0, rnd());
    push(S_MEM_RD, 1'b0, 1'b1);
    push_rst(1'b1);
    add_instr(4'h1, 1'b0, 0, 0, 1'b1, h);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL halt_rst[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    bit h;
    q.delete();
    push_rst(1'b1);
    for (int k = 0; k < (1 << CNTW) + 4; k++)
      add_instr((k % 3 == 0) ? 4'h4 : OP_BR, 1'b0, 0, 0, 1'b1, h);
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL cnt_wrap[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  task automatic test_random();
    bit         h;
    logic [3:0] op;
    logic       en_end;
    int         df, dm;
    q.delete();
    for (int r = 0; r < 4; r++) begin
      push_rst(1'b1);
      for (int n = 0; n < 25; n++) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HALT && $urandom_range(0, 3) != 0) op = 4'h1;
        df = ($urandom_range(0, 11) == 0) ? TIMEOUT - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
        dm = ($urandom_range(0, 11) == 0) ? TIMEOUT - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
        en_end = ($urandom_range(0, 3) != 0);
        add_instr(op, rnd(), df, dm, en_end, h);
        if (h) begin
          add_halt(int'($urandom_range(2, 5)));
          break;
        end
        if (!en_end) add_idle(int'($urandom_range(1, 3)), 1'b1);
      end
    end
    foreach (q[i]) begin
      step(q[i]);
      vectors++;
      if (obs_vec() !== exp_vec(q[i])) begin
        miscompares++;
        $display("FAIL random[%0d]: got state=%0d strobes=%b err=%b cnt=%0d, expected state=%0d strobes=%b err=%b cnt=%0d",
                 i, bus.state, strb_obs(), bus.err_timeout, bus.instr_cnt, q[i].st, strobes_of(q[i].st), q[i].err, q[i].cnt);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.opcode  = 4'h0;
    bus.br_flag = 1'b0;
    prv.st  = S_IDLE;
    prv.rdy = 1'b1;
    prv.en  = 1'b0;
    prv.op  = 4'h0;
    prv.br  = 1'b0;
    prv.rst = 1'b1;
    prv.err = 1'b0;
    prv.cnt = '0;
    m_cnt    = '0;
    m_err    = 1'b0;
    pend_end = 1'b0;
    @(negedge clk);
    test_reset();
    test_instr_classes();
    test_timeout();
    test_en_drop();
    test_halt_and_rst();
    test_cnt_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
